fmax_test_harness: RTL and testbench
====================================

Name: fmax_test_harness

Overview:
Parametrised registered I/O wrapper for fmax characterisation of a design-under-test (DUT) placed next to it in the top level.
- Adds configurable input and output pipeline depth.
- Adds an internal LFSR stimulus source so timing runs need no external pins.
- Adds a MISR signature compactor so functional runs can be checked deterministically from a single result word.
- Sits between the top-level pins or button logic and the DUT, clocked by clk250.

Parameters:
- WIDTH, 16: data path width of stimulus, DUT I/O and signature; legal 4..32.
- IN_STAGES, 1: register stages on in_data before the stimulus mux; legal 1..4.
- OUT_STAGES, 1: register stages on dut_out before out_data; legal 1..4.
- DUT_LATENCY, 0: clock cycles from dut_in to dut_out inside the DUT; legal 0..16.
- RUN_CYCLES, 1024: stimulus words issued per run; legal 1..2^20.
- LFSR_SEED, 1: LFSR reset/restart value; must be nonzero.

Ports:
- clk250, in, 1: system clock.
- nrst, in, 1: reset, synchronous, active-low.
- start, in, 1: single-cycle pulse, e.g. debounced key rising edge; begins a run.
- mode, in, 1: stimulus select. 0 = pipelined in_data, 1 = internal LFSR. Sampled only when start is accepted.
- in_data, in, WIDTH: external stimulus from pins.
- dut_in, out, WIDTH: registered stimulus to DUT.
- dut_out, in, WIDTH: DUT result.
- out_data, out, WIDTH: last OUT_STAGES register of dut_out, to pins.
- busy, out, 1: high in RUN or FLUSH.
- done, out, 1: high in DONE.
- signature, out, WIDTH: MISR value; stable while done=1.
- run_cnt, out, $clog2(RUN_CYCLES+1): stimulus words issued in the current or last run.

Behaviour:
Reset:
- nrst low at an edge clears all pipeline registers, dut_in, out_data, the valid pipe, signature and run_cnt to 0.
- LFSR loads LFSR_SEED; the latched mode clears to 0; state goes to IDLE; busy=0, done=0.
- nrst takes priority over start. Reset mid-run aborts the run with no residue.

State machine (states IDLE, RUN, FLUSH, DONE):
- IDLE: on start, latch mode, clear MISR and run_cnt, load LFSR_SEED, go to RUN.
- RUN: on every edge, load dut_in with stim, push 1 into the valid pipe, advance the LFSR if mode=1, and increment run_cnt. When run_cnt reaches RUN_CYCLES-1 on that edge, go to FLUSH.
- FLUSH: push 0 into the valid pipe; when the valid pipe is empty after the MISR absorb, go to DONE.
- DONE: hold signature. start restarts exactly as from IDLE.
- start in RUN or FLUSH is ignored.

Datapath:
- stim = LFSR value if latched mode=1, else the IN_STAGES-delayed in_data.
- Outside RUN, dut_in still updates every cycle from the IN_STAGES path. The LFSR holds. The valid pipe inserts 0.
- The valid pipe has length 1+DUT_LATENCY+OUT_STAGES and runs alongside the data path.
- The MISR absorbs out_data on the edge after the valid bit reaches the out_data stage:
  sig <= {sig[W-2:0], fb(sig)} ^ out_data
- Timing: start sampled at edge E0 gives the first dut_in load at E1. done rises at edge E0+RUN_CYCLES+DUT_LATENCY+OUT_STAGES+1.
- LFSR: Fibonacci, shift left, lfsr <= {lfsr[W-2:0], fb(lfsr)}. fb is the XOR of the tap bits for WIDTH from the package table. MISR fb uses the same taps.
  - WIDTH=8 taps are bits 7, 5, 4, 3.
- All arithmetic is unsigned. run_cnt saturates at RUN_CYCLES and never wraps.

Decomposition:
- Package fmax_harness_pkg holds:
  - state_t enum: IDLE, RUN, FLUSH, DONE.
  - function lfsr_taps(int width) returning a WIDTH-bit maximal-length tap mask for widths 4..32.
  - localparam RUN_CNT_W helper.
- One sub-module, lfsr_misr (parameters WIDTH and SEED; inputs ena, load, din, misr_mode). Instantiated twice: once as stimulus LFSR (din=0), once as MISR (seed 0).

Test Plan:
1. Reset: nrst low 3 cycles with start pulsing -> busy=0, done=0, signature=0, out_data=0, run_cnt=0.
2. LFSR sequence: WIDTH=8, mode=1, RUN_CYCLES=5, DUT_LATENCY=0, identity DUT, start at E0 -> dut_in = 01, 02, 04, 08, 11 after E1..E5; busy 1 from E0; done rises at E7; run_cnt=5.
3. Zero data: mode=0, in_data=0, RUN_CYCLES=16 -> signature=0 at done; done held until next start.
4. Latency: DUT_LATENCY=3 registered identity, OUT_STAGES=2, RUN_CYCLES=5 -> done rises at E0+11; signature equals the reference model's signature for the same stimulus.
5. Restart and ignore: start pulse during RUN -> no effect, done at the same edge. Second start in DONE -> done drops next cycle, and with mode=1 the identical signature is reproduced.
6. Abort: nrst low 1 cycle at E3 of a mode=1 run -> IDLE, all cleared. A fresh run then yields the same signature as test 5, and simultaneous start+nrst is ignored.

Source files
------------

// File: rtl/fmax_harness_pkg.sv
// Shared types and helpers for the fmax characterisation harness:
// FSM state encoding, maximal-length LFSR tap table and counter sizing.
package fmax_harness_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Tap masks use bit index n-1 for tap n of the classic maximal-length tables.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      32'sd4:  taps = 32'h0000_000C;
      32'sd5:  taps = 32'h0000_0014;
      32'sd6:  taps = 32'h0000_0030;
      32'sd7:  taps = 32'h0000_0060;
      32'sd8:  taps = 32'h0000_00B8;
      32'sd9:  taps = 32'h0000_0110;
      32'sd10: taps = 32'h0000_0240;
      32'sd11: taps = 32'h0000_0500;
      32'sd12: taps = 32'h0000_0829;
      32'sd13: taps = 32'h0000_100D;
      32'sd14: taps = 32'h0000_2015;
      32'sd15: taps = 32'h0000_6000;
      32'sd16: taps = 32'h0000_D008;
      32'sd17: taps = 32'h0001_2000;
      32'sd18: taps = 32'h0002_0400;
      32'sd19: taps = 32'h0004_0023;
      32'sd20: taps = 32'h0009_0000;
      32'sd21: taps = 32'h0014_0000;
      32'sd22: taps = 32'h0030_0000;
      32'sd23: taps = 32'h0042_0000;
      32'sd24: taps = 32'h00E1_0000;
      32'sd25: taps = 32'h0120_0000;
      32'sd26: taps = 32'h0200_0023;
      32'sd27: taps = 32'h0400_0013;
      32'sd28: taps = 32'h0900_0000;
      32'sd29: taps = 32'h1400_0000;
      32'sd30: taps = 32'h2000_0029;
      32'sd31: taps = 32'h4800_0000;
      default: taps = 32'h8020_0003;
    endcase
    return taps;
  endfunction

  function automatic logic tap_parity(input logic [31:0] value, input logic [31:0] taps);
    return ^(value & taps);
  endfunction

  function automatic int run_cnt_w(input int run_cycles);
    return $clog2(run_cycles + 1);
  endfunction

endpackage

// File: rtl/fmax_harness_lfsr_misr.sv
// Fibonacci shift-left LFSR that doubles as a MISR when misr_mode folds din
// into every shift. Used both as the stimulus source and the signature compactor.
module lfsr_misr
  import fmax_harness_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk250,
  input  logic             nrst,
  input  logic             ena,
  input  logic             load,
  input  logic             misr_mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  localparam logic [31:0] TAPS = lfsr_taps(WIDTH);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] mix_s;
  logic             fb_s;

  // Feedback bit and optional data fold-in
  always_comb begin
    fb_s = tap_parity(32'(q_r), TAPS);
    if (misr_mode) begin
      mix_s = din;
    end else begin
      mix_s = '0;
    end
  end

  // Shift register; load restarts from the seed and wins over ena
  always_ff @(posedge clk250) begin
    if (!nrst) begin
      q_r <= SEED;
    end else if (load) begin
      q_r <= SEED;
    end else if (ena) begin
      q_r <= {q_r[WIDTH-2:0], fb_s} ^ mix_s;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/fmax_test_harness.sv
// Registered I/O wrapper for fmax runs: pipelined pins, LFSR stimulus, a valid
// pipe that tracks words through the DUT, and a MISR over the returned data.
module fmax_test_harness
  import fmax_harness_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter int          IN_STAGES   = 1,
  parameter int          OUT_STAGES  = 1,
  parameter int          DUT_LATENCY = 0,
  parameter int          RUN_CYCLES  = 1024,
  parameter logic [31:0] LFSR_SEED   = 32'd1,
  localparam int         CNT_W       = run_cnt_w(RUN_CYCLES)
) (
  input  logic             clk250,
  input  logic             nrst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] run_cnt
);

  // One valid bit per word between dut_in and out_data
  localparam int               VLEN     = 1 + DUT_LATENCY + OUT_STAGES;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RUN_CYCLES);

  state_t           state_r;
  state_t           state_next_s;
  logic             mode_r;
  logic             start_ok_s;
  logic             running_s;
  logic [WIDTH-1:0] in_pipe_r [IN_STAGES];
  logic [WIDTH-1:0] out_pipe_r [OUT_STAGES];
  logic [VLEN-1:0]  valid_r;
  logic [WIDTH-1:0] dut_in_r;
  logic [CNT_W-1:0] run_cnt_r;
  logic [WIDTH-1:0] lfsr_s;
  logic [WIDTH-1:0] sig_s;
  logic [WIDTH-1:0] stim_s;

  // Next-state decode; start is only honoured from IDLE or DONE
  always_comb begin
    state_next_s = state_r;
    start_ok_s   = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_next_s = RUN;
          start_ok_s   = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      RUN: begin
        if (run_cnt_r == LAST_CNT) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = RUN;
        end
      end
      FLUSH: begin
        // Last valid word is being absorbed when only the top bit remains
        if (valid_r[VLEN-2:0] == '0) begin
          state_next_s = DONE;
        end else begin
          state_next_s = FLUSH;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Stimulus select; the LFSR only drives the DUT during RUN
  always_comb begin
    running_s = (state_r == RUN);
    if (running_s && mode_r) begin
      stim_s = lfsr_s;
    end else begin
      stim_s = in_pipe_r[IN_STAGES-1];
    end
  end

  // State register and latched stimulus mode
  always_ff @(posedge clk250) begin
    if (!nrst) begin
      state_r <= IDLE;
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (start_ok_s) begin
        mode_r <= mode;
      end
    end
  end

  // Input, DUT-facing and output pipelines plus the valid pipe
  always_ff @(posedge clk250) begin
    if (!nrst) begin
      for (int i = 0; i < IN_STAGES; i++) in_pipe_r[i] <= '0;
      for (int i = 0; i < OUT_STAGES; i++) out_pipe_r[i] <= '0;
      dut_in_r <= '0;
      valid_r  <= '0;
    end else begin
      in_pipe_r[0] <= in_data;
      for (int i = 1; i < IN_STAGES; i++) in_pipe_r[i] <= in_pipe_r[i-1];
      out_pipe_r[0] <= dut_out;
      for (int i = 1; i < OUT_STAGES; i++) out_pipe_r[i] <= out_pipe_r[i-1];
      dut_in_r <= stim_s;
      valid_r  <= {valid_r[VLEN-2:0], running_s};
    end
  end

  // Issued-word counter, saturating at RUN_CYCLES
  always_ff @(posedge clk250) begin
    if (!nrst) begin
      run_cnt_r <= '0;
    end else if (start_ok_s) begin
      run_cnt_r <= '0;
    end else if (running_s && (run_cnt_r != FULL_CNT)) begin
      run_cnt_r <= run_cnt_r + CNT_W'(1);
    end
  end

  lfsr_misr #(
    .WIDTH (WIDTH),
    .SEED  (WIDTH'(LFSR_SEED))
  ) u_stim_lfsr (
    .clk250    (clk250),
    .nrst      (nrst),
    .ena       (running_s && mode_r),
    .load      (start_ok_s),
    .misr_mode (1'b0),
    .din       ({WIDTH{1'b0}}),
    .q         (lfsr_s)
  );

  lfsr_misr #(
    .WIDTH (WIDTH),
    .SEED  ({WIDTH{1'b0}})
  ) u_sig_misr (
    .clk250    (clk250),
    .nrst      (nrst),
    .ena       (valid_r[VLEN-1]),
    .load      (start_ok_s),
    .misr_mode (1'b1),
    .din       (out_pipe_r[OUT_STAGES-1]),
    .q         (sig_s)
  );

  assign dut_in    = dut_in_r;
  assign out_data  = out_pipe_r[OUT_STAGES-1];
  assign busy      = (state_r == RUN) || (state_r == FLUSH);
  assign done      = (state_r == DONE);
  assign signature = sig_s;
  assign run_cnt   = run_cnt_r;

endmodule

// File: tb/tb_fmax_test_harness.sv
// Bench for fmax_test_harness with an 8-bit, 3-cycle registered identity DUT.
// Expected words are queued as they enter the DUT and compared when they reach out_data.
module tb_fmax_test_harness;

  localparam int W      = 8;
  localparam int INS    = 2;
  localparam int OUTS   = 2;
  localparam int LAT    = 3;
  localparam int RC     = 5;
  localparam int DONE_K = RC + LAT + OUTS + 1;

  typedef struct {
    int           due;
    logic [W-1:0] val;
  } exp_t;

  logic         clk250 = 1'b0;
  logic         nrst;
  logic         start;
  logic         mode;
  logic [W-1:0] in_data;
  logic [W-1:0] dut_in;
  logic [W-1:0] dut_out;
  logic [W-1:0] out_data;
  logic         busy;
  logic         done;
  logic [W-1:0] signature;
  logic [2:0]   run_cnt;
  logic [W-1:0] d1, d2, d3;

  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic [W-1:0] hist [0:1023];
  exp_t         sb [$];
  logic [W-1:0] lfsr_exp [RC] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
  logic [W-1:0] sig_a, sig_b;

  always #2 clk250 = ~clk250;

  // Three-stage registered identity standing in for the real DUT
  always @(posedge clk250) begin
    d1 <= dut_in;
    d2 <= d1;
    d3 <= d2;
  end
  assign dut_out = d3;

  fmax_test_harness #(
    .WIDTH       (W),
    .IN_STAGES   (INS),
    .OUT_STAGES  (OUTS),
    .DUT_LATENCY (LAT),
    .RUN_CYCLES  (RC),
    .LFSR_SEED   (32'd1)
  ) u_dut (
    .clk250    (clk250),
    .nrst      (nrst),
    .start     (start),
    .mode      (mode),
    .in_data   (in_data),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .signature (signature),
    .run_cnt   (run_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: record the in_data seen at this edge, then sample after it
  task automatic tick();
    hist[cyc] = in_data;
    @(posedge clk250);
    #1;
    cyc++;
  endtask

  function automatic logic [W-1:0] misr_step(input logic [W-1:0] s, input logic [W-1:0] d);
    return {s[W-2:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ d;
  endfunction

  task automatic do_run(input logic m, input logic poke, input logic zero,
                        output logic [W-1:0] sig_model);
    int           e0;
    exp_t         x;
    logic [W-1:0] w;
    sig_model = '0;
    mode      = m;
    start     = 1'b1;
    in_data   = zero ? 8'h00 : W'($urandom);
    e0        = cyc;
    tick();
    start = 1'b0;
    check("busy_e0", busy, 1);
    check("done_e0", done, 0);
    check("cnt_e0", run_cnt, 0);
    for (int k = 1; k <= DONE_K; k++) begin
      mode    = ~m;
      start   = poke && (k == 2);
      in_data = zero ? 8'h00 : W'($urandom);
      tick();
      if (k <= RC) begin
        w = m ? lfsr_exp[k-1] : hist[e0 + k - INS];
        check("dut_in", dut_in, w);
        sb.push_back('{due: e0 + k + LAT + OUTS, val: w});
      end
      check("run_cnt", run_cnt, (k < RC) ? k : RC);
      if (sb.size() > 0 && sb[0].due == e0 + k) begin
        x = sb.pop_front();
        check("out_data", out_data, x.val);
        sig_model = misr_step(sig_model, x.val);
      end
      check("busy", busy, k < DONE_K);
      check("done", done, k == DONE_K);
    end
    check("signature", signature, sig_model);
    start = 1'b0;
    for (int h = 0; h < 3; h++) begin
      in_data = W'($urandom);
      tick();
      check("done_hold", done, 1);
      check("sig_hold", signature, sig_model);
    end
  endtask

  initial begin
    nrst    = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    in_data = 8'h00;

    // Reset with start pulsing
    for (int i = 0; i < 3; i++) begin
      start = (i % 2 == 0);
      tick();
    end
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sig", signature, 0);
    check("rst_out", out_data, 0);
    check("rst_cnt", run_cnt, 0);
    check("rst_dut_in", dut_in, 0);
    start = 1'b0;
    nrst  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("idle_busy", busy, 0);

    // LFSR run
    do_run(1'b1, 1'b0, 1'b0, sig_a);

    // All-zero external data
    in_data = 8'h00;
    tick();
    tick();
    do_run(1'b0, 1'b0, 1'b1, sig_b);
    check("zero_sig", signature, 8'h00);

    // Random external data
    do_run(1'b0, 1'b0, 1'b0, sig_b);

    // Restart from DONE with a start pulse landing mid-run
    do_run(1'b1, 1'b1, 1'b0, sig_b);
    check("restart_sig", signature, sig_a);

    // Abort mid-run
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sig", signature, 0);
    check("abort_cnt", run_cnt, 0);
    check("abort_out", out_data, 0);
    check("abort_dut_in", dut_in, 0);

    // Reset wins over a simultaneous start
    nrst  = 1'b0;
    start = 1'b1;
    tick();
    nrst  = 1'b1;
    start = 1'b0;
    check("rst_start_busy", busy, 0);
    for (int i = 0; i < 3; i++) tick();
    check("rst_start_idle", busy, 0);
    check("rst_start_done", done, 0);

    // Fresh run reproduces the LFSR signature
    do_run(1'b1, 1'b0, 1'b0, sig_b);
    check("fresh_sig", signature, sig_a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
